// File: rtl/parameters_ram.sv
// Shared RAM geometry: data word width and address width.
// Ports: none (package of localparams only).
package parameters_ram;

    localparam int DATA_WIDTH     = 8;
    localparam int ADDR_BUS_WIDTH = 4;

endpackage

// File: rtl/ram_arb_pkg.sv
// Types shared by the two-master RAM arbiter and its grant logic.
// Ports: none (state enum, master index, latched request bundle).
package ram_arb_pkg;

    import parameters_ram::*;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } ram_arb_state_e;

    typedef logic ram_arb_id_t;

    typedef struct packed {
        logic                      we;
        logic [ADDR_BUS_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0]     wdata;
    } ram_arb_req_t;

endpackage

// File: rtl/ram_arb_rr2.sv
// Two-way grant logic; round-robin with a priority register when
// RAM_ARB_RR_EN is defined, otherwise fixed priority (m0 wins ties).
// Ports: clk, rst_n, req[1:0] valids, accept (handshake taken),
//        gnt[1:0] one-hot grant, gnt_id winning master index.
module ram_arb_rr2
    import ram_arb_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  req,
    input  logic        accept,
    output logic [1:0]  gnt,
    output ram_arb_id_t gnt_id
);

`ifdef RAM_ARB_RR_EN
    // Master preferred on a tie; the other one after each accept.
    ram_arb_id_t prio_q;

    always_comb begin
        gnt_id = req[1] & (~req[0] | prio_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_q <= 1'b0;
        end else if (accept) begin
            prio_q <= ~gnt_id;
        end
    end
`else
    logic fixed_unused;

    assign fixed_unused = ^{clk, rst_n, accept};

    always_comb begin
        gnt_id = req[1] & ~req[0];
    end
`endif

    always_comb begin
        gnt[1] = gnt_id;
        gnt[0] = req[0] & ~gnt_id;
    end

endmodule

// File: rtl/ram_arbiter.sv
// Two-master valid/ready front end for a single-port synchronous RAM.
// Ports: m0_*/m1_* request and response channels, RAM command outputs
//        address_loc/data_inbit/write_en/read_en, RAM read data_outbit.
//        Arbitration mode selected by RAM_ARB_RR_EN (see ram_arb_rr2).
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int DATA_WIDTH     = parameters_ram::DATA_WIDTH,
    parameter int ADDR_BUS_WIDTH = parameters_ram::ADDR_BUS_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst_n,

    input  logic                      m0_req_valid,
    output logic                      m0_req_ready,
    input  logic                      m0_req_we,
    input  logic [ADDR_BUS_WIDTH-1:0] m0_req_addr,
    input  logic [DATA_WIDTH-1:0]     m0_req_wdata,
    output logic                      m0_rsp_valid,
    output logic [DATA_WIDTH-1:0]     m0_rsp_data,

    input  logic                      m1_req_valid,
    output logic                      m1_req_ready,
    input  logic                      m1_req_we,
    input  logic [ADDR_BUS_WIDTH-1:0] m1_req_addr,
    input  logic [DATA_WIDTH-1:0]     m1_req_wdata,
    output logic                      m1_rsp_valid,
    output logic [DATA_WIDTH-1:0]     m1_rsp_data,

    output logic [ADDR_BUS_WIDTH-1:0] address_loc,
    output logic [DATA_WIDTH-1:0]     data_inbit,
    output logic                      write_en,
    output logic                      read_en,
    input  logic [DATA_WIDTH-1:0]     data_outbit
);

    ram_arb_state_e state_q;
    ram_arb_req_t   req_q;
    ram_arb_req_t   sel;
    ram_arb_id_t    id_q;
    ram_arb_id_t    gnt_id;
    logic [1:0]     gnt;
    logic           hs;

    ram_arb_rr2 u_rr2 (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    ({m1_req_valid, m0_req_valid}),
        .accept (hs),
        .gnt    (gnt),
        .gnt_id (gnt_id)
    );

    // Readiness is forced low while reset is held.
    assign m0_req_ready = rst_n && (state_q == IDLE) && gnt[0];
    assign m1_req_ready = rst_n && (state_q == IDLE) && gnt[1];
    assign hs           = m0_req_ready | m1_req_ready;

    always_comb begin
        sel.we    = gnt_id ? m1_req_we    : m0_req_we;
        sel.addr  = gnt_id ? m1_req_addr  : m0_req_addr;
        sel.wdata = gnt_id ? m1_req_wdata : m0_req_wdata;
    end

    // RAM address/data come straight from the latched request flops.
    assign address_loc = req_q.addr;
    assign data_inbit  = req_q.wdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            req_q        <= '0;
            id_q         <= 1'b0;
            write_en     <= 1'b0;
            read_en      <= 1'b0;
            m0_rsp_valid <= 1'b0;
            m1_rsp_valid <= 1'b0;
            m0_rsp_data  <= '0;
            m1_rsp_data  <= '0;
        end else begin
            write_en     <= 1'b0;
            read_en      <= 1'b0;
            m0_rsp_valid <= 1'b0;
            m1_rsp_valid <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (hs) begin
                        req_q.we   <= sel.we;
                        req_q.addr <= sel.addr;
                        // Reads leave the last write data on the bus.
                        if (sel.we) begin
                            req_q.wdata <= sel.wdata;
                        end
                        id_q     <= gnt_id;
                        write_en <= sel.we;
                        read_en  <= ~sel.we;
                        state_q  <= ACCESS;
                    end
                end
                ACCESS: begin
                    state_q <= req_q.we ? IDLE : RESP;
                end
                RESP: begin
                    if (id_q) begin
                        m1_rsp_data  <= data_outbit;
                        m1_rsp_valid <= 1'b1;
                    end else begin
                        m0_rsp_data  <= data_outbit;
                        m0_rsp_valid <= 1'b1;
                    end
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed self-checking bench for ram_arbiter with a behavioural RAM.
// Expected values are hand-computed; RAM word i starts as 0x10+i.
module tb_ram_arbiter;

    localparam int DW = 8;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          m0_req_valid, m0_req_ready, m0_req_we;
    logic [AW-1:0] m0_req_addr;
    logic [DW-1:0] m0_req_wdata;
    logic          m0_rsp_valid;
    logic [DW-1:0] m0_rsp_data;
    logic          m1_req_valid, m1_req_ready, m1_req_we;
    logic [AW-1:0] m1_req_addr;
    logic [DW-1:0] m1_req_wdata;
    logic          m1_rsp_valid;
    logic [DW-1:0] m1_rsp_data;
    logic [AW-1:0] address_loc;
    logic [DW-1:0] data_inbit;
    logic          write_en, read_en;
    logic [DW-1:0] data_outbit;

    always #5 clk = ~clk;

    ram_arbiter dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .m0_req_valid (m0_req_valid),
        .m0_req_ready (m0_req_ready),
        .m0_req_we    (m0_req_we),
        .m0_req_addr  (m0_req_addr),
        .m0_req_wdata (m0_req_wdata),
        .m0_rsp_valid (m0_rsp_valid),
        .m0_rsp_data  (m0_rsp_data),
        .m1_req_valid (m1_req_valid),
        .m1_req_ready (m1_req_ready),
        .m1_req_we    (m1_req_we),
        .m1_req_addr  (m1_req_addr),
        .m1_req_wdata (m1_req_wdata),
        .m1_rsp_valid (m1_rsp_valid),
        .m1_rsp_data  (m1_rsp_data),
        .address_loc  (address_loc),
        .data_inbit   (data_inbit),
        .write_en     (write_en),
        .read_en      (read_en),
        .data_outbit  (data_outbit)
    );

    // Behavioural single-port RAM, one-cycle read latency.
    logic [DW-1:0] mem [16];
    logic          ram_init;

    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < 16; i++) mem[i] <= 8'(8'h10 + i);
        end else if (write_en) begin
            mem[address_loc] <= data_inbit;
        end
        if (read_en) data_outbit <= mem[address_loc];
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        m0_req_valid = 0; m0_req_we = 0; m0_req_addr = '0; m0_req_wdata = '0;
        m1_req_valid = 0; m1_req_we = 0; m1_req_addr = '0; m1_req_wdata = '0;
    endtask

    task automatic do_reset();
        idle_in();
        rst_n = 0;
        tick();
        tick();
        rst_n = 1;
    endtask

    typedef struct {
        logic          v0, we0;
        logic [AW-1:0] a0;
        logic [DW-1:0] d0;
        logic          v1, we1;
        logic [AW-1:0] a1;
        logic [DW-1:0] d1;
        logic [1:0]    rdy;   // {m1, m0}
        logic [1:0]    stb;   // {write_en, read_en}
        logic [AW-1:0] addr;
        logic [DW-1:0] din;
        logic [1:0]    rv;    // {m1, m0}
        logic [DW-1:0] rsp0, rsp1;
    } vec_t;

    function automatic vec_t mk(
        logic v0, logic we0, logic [AW-1:0] a0, logic [DW-1:0] d0,
        logic v1, logic we1, logic [AW-1:0] a1, logic [DW-1:0] d1,
        logic [1:0] rdy, logic [1:0] stb, logic [AW-1:0] addr,
        logic [DW-1:0] din, logic [1:0] rv,
        logic [DW-1:0] rsp0, logic [DW-1:0] rsp1);
        vec_t v;
        v.v0 = v0; v.we0 = we0; v.a0 = a0; v.d0 = d0;
        v.v1 = v1; v.we1 = we1; v.a1 = a1; v.d1 = d1;
        v.rdy = rdy; v.stb = stb; v.addr = addr; v.din = din;
        v.rv = rv; v.rsp0 = rsp0; v.rsp1 = rsp1;
        return v;
    endfunction

    vec_t vecs [20];

    logic [33:0] act_o, exp_o;
    int          cnt, bad, both;
    int          gq [$];
    int          rv0_n, rv1_n;
    int          wcyc [$];
    int          waddr [$];
    int          wdat [$];
    int          idx;
    logic        hs;
    logic [3:0]  g_exp;
    int          exp_rv0, exp_rv1;

    initial begin
        // m0 write 3/A5, m0 read 3, read/write race on 7, m1 read 3.
        vecs[0]  = mk(1,1,3,8'hA5, 0,0,0,0, 2'b01,2'b00,0,8'h00,2'b00,8'h00,8'h00);
        vecs[1]  = mk(0,0,0,0,     0,0,0,0, 2'b00,2'b10,3,8'hA5,2'b00,8'h00,8'h00);
        vecs[2]  = mk(1,0,3,0,     0,0,0,0, 2'b01,2'b00,3,8'hA5,2'b00,8'h00,8'h00);
        vecs[3]  = mk(0,0,0,0,     0,0,0,0, 2'b00,2'b01,3,8'hA5,2'b00,8'h00,8'h00);
        vecs[4]  = mk(0,0,0,0,     0,0,0,0, 2'b00,2'b00,3,8'hA5,2'b00,8'h00,8'h00);
        vecs[5]  = mk(0,0,0,0,     0,0,0,0, 2'b00,2'b00,3,8'hA5,2'b01,8'hA5,8'h00);
        vecs[6]  = mk(0,0,0,0,     0,0,0,0, 2'b00,2'b00,3,8'hA5,2'b00,8'hA5,8'h00);
        vecs[7]  = mk(1,0,7,0,     0,0,0,0, 2'b01,2'b00,3,8'hA5,2'b00,8'hA5,8'h00);
        vecs[8]  = mk(0,0,0,0,     0,0,0,0, 2'b00,2'b01,7,8'hA5,2'b00,8'hA5,8'h00);
        vecs[9]  = mk(0,0,0,0,     0,0,0,0, 2'b00,2'b00,7,8'hA5,2'b00,8'hA5,8'h00);
        vecs[10] = mk(0,0,0,0,     1,1,7,8'hC3, 2'b10,2'b00,7,8'hA5,2'b01,8'h17,8'h00);
        vecs[11] = mk(0,0,0,0,     0,0,0,0, 2'b00,2'b10,7,8'hC3,2'b00,8'h17,8'h00);
        vecs[12] = mk(1,0,7,0,     0,0,0,0, 2'b01,2'b00,7,8'hC3,2'b00,8'h17,8'h00);
        vecs[13] = mk(0,0,0,0,     0,0,0,0, 2'b00,2'b01,7,8'hC3,2'b00,8'h17,8'h00);
        vecs[14] = mk(0,0,0,0,     0,0,0,0, 2'b00,2'b00,7,8'hC3,2'b00,8'h17,8'h00);
        vecs[15] = mk(0,0,0,0,     0,0,0,0, 2'b00,2'b00,7,8'hC3,2'b01,8'hC3,8'h00);
        vecs[16] = mk(0,0,0,0,     1,0,3,0, 2'b10,2'b00,7,8'hC3,2'b00,8'hC3,8'h00);
        vecs[17] = mk(0,0,0,0,     0,0,0,0, 2'b00,2'b01,3,8'hC3,2'b00,8'hC3,8'h00);
        vecs[18] = mk(0,0,0,0,     0,0,0,0, 2'b00,2'b00,3,8'hC3,2'b00,8'hC3,8'h00);
        vecs[19] = mk(0,0,0,0,     0,0,0,0, 2'b00,2'b00,3,8'hC3,2'b10,8'hC3,8'hA5);

        // Reset state, with a request held to show ready is gated.
        idle_in();
        rst_n    = 0;
        ram_init = 1;
        m0_req_valid = 1;
        tick();
        tick();
        chk("reset_state",
            {write_en, read_en, m1_req_ready, m0_req_ready, m1_rsp_valid,
             m0_rsp_valid, address_loc, data_inbit, m0_rsp_data, m1_rsp_data},
            64'h0);
        ram_init = 0;
        idle_in();
        rst_n = 1;

        // Reset in the middle of an m1 read.
        m1_req_valid = 1; m1_req_we = 0; m1_req_addr = 4'd5;
        #1;
        chk("midrst_handshake", m1_req_ready, 1);
        tick();
        idle_in();
        #1;
        chk("midrst_read_en", read_en, 1);
        m0_req_valid = 1; m1_req_valid = 1;
        #1;
        rst_n = 0;
        #1;
        chk("midrst_outputs",
            {read_en, write_en, m0_req_ready, m1_req_ready,
             m0_rsp_valid, m1_rsp_valid}, 0);
        tick();
        idle_in();
        rst_n = 1;
        cnt = 0;
        for (int c = 0; c < 5; c++) begin
            #1;
            if (m0_rsp_valid || m1_rsp_valid || read_en) cnt++;
            tick();
        end
        chk("midrst_no_rsp", cnt, 0);
        m1_req_valid = 1; m1_req_we = 0; m1_req_addr = 4'd5;
        #1;
        chk("midrst_idle", m1_req_ready, 1);

        // Table-driven single-cycle vectors.
        do_reset();
        for (int i = 0; i < 20; i++) begin
            m0_req_valid = vecs[i].v0; m0_req_we = vecs[i].we0;
            m0_req_addr  = vecs[i].a0; m0_req_wdata = vecs[i].d0;
            m1_req_valid = vecs[i].v1; m1_req_we = vecs[i].we1;
            m1_req_addr  = vecs[i].a1; m1_req_wdata = vecs[i].d1;
            #1;
            act_o = {m1_req_ready, m0_req_ready, write_en, read_en,
                     address_loc, data_inbit, m1_rsp_valid, m0_rsp_valid,
                     m0_rsp_data, m1_rsp_data};
            exp_o = {vecs[i].rdy, vecs[i].stb, vecs[i].addr, vecs[i].din,
                     vecs[i].rv, vecs[i].rsp0, vecs[i].rsp1};
            chk($sformatf("vec%0d", i), act_o, exp_o);
            tick();
        end
        idle_in();

        // Both masters hold reads: m0 addr 1, m1 addr 2.
        do_reset();
        m0_req_valid = 1; m0_req_we = 0; m0_req_addr = 4'd1;
        m1_req_valid = 1; m1_req_we = 0; m1_req_addr = 4'd2;
        both = 0; bad = 0; rv0_n = 0; rv1_n = 0;
        gq.delete();
        for (int c = 0; c < 13; c++) begin
            #1;
            if (m0_req_ready && m1_req_ready) both++;
            if (m0_req_ready) gq.push_back(0);
            if (m1_req_ready) gq.push_back(1);
            if (m0_rsp_valid) begin
                rv0_n++;
                if (m0_rsp_data !== 8'h11) bad++;
            end
            if (m1_rsp_valid) begin
                rv1_n++;
                if (m1_rsp_data !== 8'h12) bad++;
            end
            tick();
        end
        idle_in();
`ifdef RAM_ARB_RR_EN
        g_exp   = 4'b1010;
        exp_rv0 = 2;
        exp_rv1 = 2;
`else
        g_exp   = 4'b0000;
        exp_rv0 = 4;
        exp_rv1 = 0;
`endif
        chk("rr_both_ready", both, 0);
        chk("rr_grant_count", gq.size(), 5);
        for (int k = 0; k < 4; k++) begin
            if (k < gq.size()) begin
                chk($sformatf("rr_grant%0d", k), gq[k], g_exp[k]);
            end else begin
                chk($sformatf("rr_grant%0d", k), 64'hFFFF, g_exp[k]);
            end
        end
        chk("rr_rsp_data", bad, 0);
        chk("rr_m0_rsp_count", rv0_n, exp_rv0);
        chk("rr_m1_rsp_count", rv1_n, exp_rv1);
        for (int c = 0; c < 4; c++) tick();

        // Back-to-back m1 writes to addresses 0..15.
        do_reset();
        idx = 0;
        m1_req_valid = 1; m1_req_we = 1;
        m1_req_addr  = 4'd0; m1_req_wdata = 8'hE0;
        wcyc.delete(); waddr.delete(); wdat.delete();
        for (int c = 0; c < 60; c++) begin
            #1;
            if (write_en) begin
                wcyc.push_back(c);
                waddr.push_back(int'(address_loc));
                wdat.push_back(int'(data_inbit));
            end
            hs = m1_req_ready;
            tick();
            if (hs) begin
                idx++;
                if (idx == 16) begin
                    m1_req_valid = 0;
                end else begin
                    m1_req_addr  = 4'(idx);
                    m1_req_wdata = 8'(8'hE0 + idx);
                end
            end
        end
        chk("b2b_write_count", wcyc.size(), 16);
        bad = 0;
        for (int k = 0; k < wcyc.size(); k++) begin
            if (waddr[k] != k) bad++;
            if (wdat[k] != 32'hE0 + k) bad++;
            if (k > 0 && (wcyc[k] - wcyc[k-1]) != 2) bad++;
        end
        chk("b2b_addr_data_spacing", bad, 0);
        if (wcyc.size() > 0) chk("b2b_first_write_cycle", wcyc[0], 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
